// File: rtl/main_control_fsm_if.sv
// main_control_fsm_if
//   Bundles the opcode/memory-ready inputs and every control, debug and
//   status output of the multicycle main control unit.
//   master : the control FSM (consumes opcode/mem_ready, drives controls)
//   slave  : the datapath/environment side (drives opcode/mem_ready)
//
//   opcode        IR[31:26], stable from DECODE until the next FETCH completes
//   mem_ready     memory completes the current read/write this cycle
//   pc_write      unconditional PC load
//   pc_write_cond PC load if ALU zero (gated externally)
//   i_or_d        memory address select, 0=PC, 1=ALUOut
//   mem_read      memory read request
//   mem_write     memory write request
//   ir_write      IR load
//   mem_to_reg    write-back data select, 1=MDR
//   reg_dst       destination register select, 1=rd, 0=rt
//   reg_write     register file write
//   alu_src_a     ALU A select, 0=PC, 1=A
//   alu_src_b     ALU B select, 00=B 01=4 10=simm 11=simm<<2
//   alu_op        00 add, 01 sub, 10 use funct, 11 xor
//   pc_source     00 ALU result, 01 ALUOut, 10 jump target
//   illegal       one-cycle pulse after an undefined opcode is decoded
//   state         current state code (debug)
//   retired       wrapping count of completed instructions
interface main_control_fsm_if;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        pc_write;
  logic        pc_write_cond;
  logic        i_or_d;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        mem_to_reg;
  logic        reg_dst;
  logic        reg_write;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic [1:0]  pc_source;
  logic        illegal;
  logic [3:0]  state;
  logic [15:0] retired;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal, state, retired
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal, state, retired
  );
endinterface

// File: rtl/main_control_fsm.sv
// main_control_fsm
//   Multicycle main control unit for the 32-bit processor. A Moore state
//   machine tracks the instruction phase and decodes every datapath enable,
//   mux select and the 2-bit alu_op from the current state. FETCH, MEMRD and
//   MEMWR wait on mem_ready. Retired instructions are counted (wrapping).
//
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   ctrl   main_control_fsm_if.master: opcode/mem_ready in, controls out
module main_control_fsm (
  input  logic               clk,
  input  logic               rst_n,
  main_control_fsm_if.master ctrl
);

  typedef enum logic [3:0] {
    S_RST     = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC    = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10,
    S_XORI_EX = 4'd11,
    S_XORI_WB = 4'd12
  } state_t;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011,
    OP_BEQ   = 6'b000100,
    OP_J     = 6'b000010,
    OP_XORI  = 6'b001110
  } opcode_t;

  state_t      state_q;
  state_t      state_d;
  logic        opcode_legal;
  logic        retire;
  logic        illegal_q;
  logic [15:0] retired_q;

  always_comb begin
    opcode_legal = 1'b0;
    case (ctrl.opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_XORI: opcode_legal = 1'b1;
      default:                                       opcode_legal = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_RST:     state_d = S_FETCH;
      S_FETCH:   state_d = ctrl.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (ctrl.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_XORI:      state_d = S_XORI_EX;
          default:      state_d = S_FETCH;
        endcase
      end
      // Only lw/sw reach MEMADR, and opcode is held stable, so a single
      // compare against sw picks the memory direction.
      S_MEMADR:  state_d = (ctrl.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = ctrl.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_d = ctrl.mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:    state_d = S_ALUWB;
      S_XORI_EX: state_d = S_XORI_WB;
      default:   state_d = S_FETCH;
    endcase
  end

  // Moore output decode; only pc_write/ir_write in FETCH look at an input
  always_comb begin
    ctrl.pc_write      = 1'b0;
    ctrl.pc_write_cond = 1'b0;
    ctrl.i_or_d        = 1'b0;
    ctrl.mem_read      = 1'b0;
    ctrl.mem_write     = 1'b0;
    ctrl.ir_write      = 1'b0;
    ctrl.mem_to_reg    = 1'b0;
    ctrl.reg_dst       = 1'b0;
    ctrl.reg_write     = 1'b0;
    ctrl.alu_src_a     = 1'b0;
    ctrl.alu_src_b     = 2'b00;
    ctrl.alu_op        = 2'b00;
    ctrl.pc_source     = 2'b00;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.ir_write  = ctrl.mem_ready;
        ctrl.pc_write  = ctrl.mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = 2'b11;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = 2'b10;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = 2'b01;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 2'b01;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = 2'b10;
      end
      S_XORI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = 2'b11;
      end
      S_XORI_WB: begin
        ctrl.reg_write = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // An instruction retires on the edge leaving its final state
  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_MEMWB, S_ALUWB, S_XORI_WB, S_BRANCH, S_JUMP: retire = 1'b1;
      S_MEMWR:                                       retire = ctrl.mem_ready;
      default:                                       retire = 1'b0;
    endcase
  end

  // Counter is reloaded every cycle (adding 0 when idle) so the register
  // always follows its own current value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      illegal_q <= (state_q == S_DECODE) && !opcode_legal;
      retired_q <= retired_q + {15'd0, retire};
    end
  end

  assign ctrl.illegal = illegal_q;
  assign ctrl.retired = retired_q;
  assign ctrl.state   = state_q;

endmodule
